axi4_usr_mem_ctrl: RTL and testbench

Downstream user-side responder for the AXI4 slave FSM. It consumes the FSM's user memory port (`en`/`wen`/`addr`/`bm`/`dat`) and backs it with an internal single-port word RAM. It generates the five handshake qualifiers the FSM takes as inputs (`awready`, `wready`, `bvalid`, `arready`, `rvalid`) so that AXI4 single and burst transactions complete with correct flow control. It also holds read data stable under `rready` backpressure.

---
 rtl/axi4_usr_mem_ctrl_if.sv | 58 +++++
 rtl/axi4_usr_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_axi4_usr_mem_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_usr_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// axi4_usr_mem_ctrl_if
//
// Bundles the user memory port of the AXI4 slave FSM with the AXI channel
// signals that the user-side responder snoops and the handshake qualifiers
// it returns.
//
//   master modport : the AXI4 slave FSM / bus side (drives requests, snooped
//                    channel signals and rlast; receives read data and
//                    handshake qualifiers)
//   slave modport  : axi4_usr_mem_ctrl (the responder backing the port)
//
// Signals:
//   usr_en_i, usr_wen_i, usr_addr_i, usr_bm_i, usr_dat_i : memory request
//   usr_dat_o                                            : read data register
//   awvalid_i, arvalid_i, wvalid_i, wlast_i, bready_i,
//   rready_i, rlast_i                                    : snooped bus signals
//   awready_o, wready_o, bvalid_o, arready_o, rvalid_o   : handshake qualifiers
// ---------------------------------------------------------------------------
interface axi4_usr_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                      usr_en_i;
    logic                      usr_wen_i;
    logic [ADDR_WIDTH-1:0]     usr_addr_i;
    logic [DATA_WIDTH/8-1:0]   usr_bm_i;
    logic [DATA_WIDTH-1:0]     usr_dat_i;
    logic [DATA_WIDTH-1:0]     usr_dat_o;

    logic                      awvalid_i;
    logic                      arvalid_i;
    logic                      wvalid_i;
    logic                      wlast_i;
    logic                      bready_i;
    logic                      rready_i;
    logic                      rlast_i;

    logic                      awready_o;
    logic                      wready_o;
    logic                      bvalid_o;
    logic                      arready_o;
    logic                      rvalid_o;

    modport master (
        output usr_en_i, usr_wen_i, usr_addr_i, usr_bm_i, usr_dat_i,
        output awvalid_i, arvalid_i, wvalid_i, wlast_i, bready_i, rready_i, rlast_i,
        input  usr_dat_o,
        input  awready_o, wready_o, bvalid_o, arready_o, rvalid_o
    );

    modport slave (
        input  usr_en_i, usr_wen_i, usr_addr_i, usr_bm_i, usr_dat_i,
        input  awvalid_i, arvalid_i, wvalid_i, wlast_i, bready_i, rready_i, rlast_i,
        output usr_dat_o,
        output awready_o, wready_o, bvalid_o, arready_o, rvalid_o
    );
endinterface

// File: rtl/axi4_usr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// axi4_usr_mem_ctrl
//
// User-side responder for the AXI4 slave FSM. Backs the FSM's user memory
// port with a single-port word RAM (byte-maskable writes, registered read)
// and generates the awready/wready/bvalid/arready/rvalid qualifiers so that
// single and burst transactions complete with correct flow control. The read
// data register holds its value under rready backpressure.
//
// Ports:
//   aclk     in  : clock
//   aresetn  in  : synchronous reset, active-low
//   bus      slave modport of axi4_usr_mem_ctrl_if (memory port, snooped
//            AXI signals, handshake qualifiers, read data)
//
// Optional build macro AXI4_USR_MEM_BP_EN: adds an 8-bit LFSR that randomly
// throttles wready in WR and read loads in RD to exercise backpressure.
// ---------------------------------------------------------------------------
module axi4_usr_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                aclk,
    input  logic                aresetn,
    axi4_usr_mem_ctrl_if.slave  bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t state_reg;
    logic   rd_vld_reg;
    logic   throttle;
    logic   wr_en;
    logic   ld;
    logic   rd_exit;

    logic   awready_c;
    logic   wready_c;
    logic   bvalid_c;
    logic   arready_c;
    logic   rvalid_c;

`ifdef AXI4_USR_MEM_BP_EN
    // Fibonacci LFSR, taps 8,6,5,4; bit0 decides whether this cycle stalls.
    logic [7:0] lfsr_reg;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lfsr_reg <= 8'hA5;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0],
                         lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    assign throttle = lfsr_reg[0];
`else
    assign throttle = 1'b0;
`endif

    // Handshake qualifiers are a function of state plus a few snooped inputs;
    // everything is held low while reset is asserted.
    always_comb begin
        awready_c = 1'b0;
        wready_c  = 1'b0;
        bvalid_c  = 1'b0;
        arready_c = 1'b0;
        rvalid_c  = 1'b0;
        if (aresetn) begin
            case (state_reg)
                IDLE: begin
                    arready_c = 1'b1;
                    // Read has priority; first write beat may ride with AW.
                    awready_c = !bus.arvalid_i;
                    wready_c  = !bus.arvalid_i;
                end
                WR:   wready_c = !throttle;
                RESP: bvalid_c = 1'b1;
                RD:   rvalid_c = rd_vld_reg;
                default: ;
            endcase
        end
    end

    assign bus.awready_o = awready_c;
    assign bus.wready_o  = wready_c;
    assign bus.bvalid_o  = bvalid_c;
    assign bus.arready_o = arready_c;
    assign bus.rvalid_o  = rvalid_c;

    assign wr_en   = bus.usr_en_i & bus.usr_wen_i;
    // A new word may be loaded only if the register is empty or being drained.
    assign ld      = bus.usr_en_i & !bus.usr_wen_i & (!rd_vld_reg | bus.rready_i)
                     & !(throttle & (state_reg == RD));
    assign rd_exit = (state_reg == RD) & rd_vld_reg & bus.rready_i & bus.rlast_i;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg  <= IDLE;
            rd_vld_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.arvalid_i) begin
                        state_reg <= RD;
                    end else if (bus.awvalid_i && bus.wvalid_i && bus.wlast_i) begin
                        state_reg <= RESP;
                    end else if (bus.awvalid_i) begin
                        state_reg <= WR;
                    end
                end
                WR: begin
                    if (bus.wvalid_i && wready_c && bus.wlast_i) begin
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (bus.bready_i) begin
                        state_reg <= IDLE;
                    end
                end
                RD: begin
                    if (rd_exit) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (rd_exit) begin
                rd_vld_reg <= 1'b0;
            end else if (ld) begin
                rd_vld_reg <= 1'b1;
            end else if (bus.rready_i) begin
                rd_vld_reg <= 1'b0;
            end
        end
    end

    // One RAM per byte lane so each lane maps to its own block RAM with a
    // registered read port; the read register itself is reset to zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rd_lane_reg;

            always_ff @(posedge aclk) begin
                if (wr_en && bus.usr_bm_i[gi]) begin
                    mem_lane[bus.usr_addr_i] <= bus.usr_dat_i[gi*8 +: 8];
                end
            end

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    rd_lane_reg <= 8'h00;
                end else if (ld) begin
                    rd_lane_reg <= mem_lane[bus.usr_addr_i];
                end
            end

            assign bus.usr_dat_o[gi*8 +: 8] = rd_lane_reg;
        end
    endgenerate

endmodule

// File: tb/tb_axi4_usr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi4_usr_mem_ctrl
//
// Plays the role of the AXI4 slave FSM and bus master around
// axi4_usr_mem_ctrl. A word-array model of the RAM, updated with the byte
// mask rule on every accepted write beat, supplies the expected read data.
// ---------------------------------------------------------------------------
module tb_axi4_usr_mem_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi4_usr_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi4_usr_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    // FSM-side drive
    logic          wr_mode = 1'b0;
    logic          rd_req  = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [NB-1:0] wbm = '0;
    logic          awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic          bready = 1'b0, rready = 1'b0, rlast = 1'b0;

    assign bus.usr_en_i   = wr_mode ? (wvalid & bus.wready_o) : rd_req;
    assign bus.usr_wen_i  = wr_mode;
    assign bus.usr_addr_i = cur_addr;
    assign bus.usr_bm_i   = wbm;
    assign bus.usr_dat_i  = wdata;
    assign bus.awvalid_i  = awvalid;
    assign bus.arvalid_i  = arvalid;
    assign bus.wvalid_i   = wvalid;
    assign bus.wlast_i    = wlast;
    assign bus.bready_i   = bready;
    assign bus.rready_i   = rready;
    assign bus.rlast_i    = rlast;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wbuf [256];
    logic [NB-1:0] mbuf [256];
    logic [DW-1:0] last_rd = '0;
    int n_tests = 0;
    int n_fail  = 0;
`ifdef AXI4_USR_MEM_BP_EN
    bit saw_wready_low = 1'b0;
`endif

    task automatic write_burst(input logic [AW-1:0] base, input int len, input bit gaps);
        int beat = 0, cyc = 0, wl_cyc = -1;
        bit wl_done = 0, b_done = 0, b_first = 1, aw_done = 0, hs_aw, hs_w;
        logic [AW-1:0] a;
        wr_mode = 1'b1; rd_req = 1'b0; awvalid = 1'b1; bready = 1'b0;
        cur_addr = base; wdata = wbuf[0]; wbm = mbuf[0]; wlast = (len == 0);
        wvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        while (!b_done && cyc < 3000) begin
            @(negedge aclk);
            hs_aw = awvalid & bus.awready_o;
            hs_w  = wvalid & bus.wready_o;
`ifdef AXI4_USR_MEM_BP_EN
            if (aw_done && wvalid && !bus.wready_o && !wl_done) saw_wready_low = 1'b1;
`endif
            if (hs_w) begin
                a = base + AW'(beat);
                for (int k = 0; k < NB; k++)
                    if (wbm[k]) model_mem[a][8*k +: 8] = wdata[8*k +: 8];
                if (wlast) begin wl_done = 1; wl_cyc = cyc; end
            end
            if (bus.bvalid_o && b_first) begin
                b_first = 0;
                n_tests++;
                if (!wl_done || cyc != wl_cyc + 1) begin
                    n_fail++;
                    $display("FAIL b_latency: bvalid at cycle %0d, wlast handshake at %0d (need +1)", cyc, wl_cyc);
                end
            end
            if (bus.bvalid_o && bready) b_done = 1;
            @(posedge aclk); #1;
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
            if (hs_w) begin
                beat++;
                if (wl_done) begin
                    wvalid = 1'b0; wlast = 1'b0; awvalid = 1'b0;
                end else begin
                    cur_addr = base + AW'(beat); wdata = wbuf[beat]; wbm = mbuf[beat];
                    wlast = (beat == len);
                end
            end
            if (!wl_done) wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            else          bready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        n_tests++;
        if (!b_done) begin
            n_fail++;
            $display("FAIL wr_timeout: write at %h len %0d got no B handshake, want one", base, len);
        end
        bready = 1'b0; wvalid = 1'b0; awvalid = 1'b0;
    endtask

    // rr_mode: 0 rready always high, 1 random, 2 hold low 3 cycles at beat 2
    task automatic read_burst(input logic [AW-1:0] base, input int len, input int rr_mode, input bit aw_pend);
        int recv = 0, cyc = 0, hold = 0, nxt;
        bit done = 0, got_first = 0, prv_hold = 0, hs_ar, hs_r;
        logic [DW-1:0] prv_dat = '0;
        logic [AW-1:0] a;
        wr_mode = 1'b0; arvalid = 1'b1;
        rready = (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!done && cyc < 3000) begin
            @(negedge aclk);
            hs_ar = arvalid & bus.arready_o;
            if (cyc == 0) begin
                n_tests++;
                if (bus.arready_o !== 1'b1) begin
                    n_fail++; $display("FAIL ar_ready: got %b want 1", bus.arready_o);
                end
            end
            if (aw_pend) begin
                n_tests++;
                if (bus.awready_o !== 1'b0) begin
                    n_fail++; $display("FAIL aw_blocked: awready %b during read, want 0", bus.awready_o);
                end
            end
            if (prv_hold) begin
                n_tests++;
                if (bus.rvalid_o !== 1'b1 || bus.usr_dat_o !== prv_dat) begin
                    n_fail++;
                    $display("FAIL rd_hold: rvalid %b data %h, want 1 %h", bus.rvalid_o, bus.usr_dat_o, prv_dat);
                end
            end
            if (!got_first && bus.rvalid_o) begin
                got_first = 1;
                n_tests++;
                if (cyc != 1) begin
                    n_fail++; $display("FAIL rd_latency: first rvalid %0d cycles after AR, want 1", cyc);
                end
            end
`ifndef AXI4_USR_MEM_BP_EN
            if (rr_mode == 0 && cyc >= 2) begin
                n_tests++;
                if (bus.rvalid_o !== 1'b1) begin
                    n_fail++; $display("FAIL rd_b2b: rvalid %b at cycle %0d, want 1", bus.rvalid_o, cyc);
                end
            end
`endif
            if (rr_mode == 2 && bus.rvalid_o && !rready) begin
                n_tests++;
                if (bus.usr_dat_o !== model_mem[base + AW'(2)]) begin
                    n_fail++; $display("FAIL rd_bp_data: got %h want %h", bus.usr_dat_o, model_mem[base + AW'(2)]);
                end
            end
            hs_r  = bus.rvalid_o & rready;
            rlast = (recv == len);
            if (hs_r) begin
                a = base + AW'(recv);
                n_tests++;
                if (bus.usr_dat_o !== model_mem[a]) begin
                    n_fail++; $display("FAIL rd_data: addr %h beat %0d got %h want %h", a, recv, bus.usr_dat_o, model_mem[a]);
                end
                last_rd = bus.usr_dat_o;
                if (recv == len) done = 1;
            end
            // Word wanted at this edge: the one after the currently held beat.
            nxt      = recv + (bus.rvalid_o ? 1 : 0);
            rd_req   = !done && (nxt <= len);
            cur_addr = base + AW'(nxt);
            if (hs_r) recv++;
            prv_hold = bus.rvalid_o & !rready;
            prv_dat  = bus.usr_dat_o;
            @(posedge aclk); #1;
            if (hs_ar) arvalid = 1'b0;
            case (rr_mode)
                1: rready = 1'($urandom_range(0, 1));
                2: if (recv == 2 && hold < 3) begin rready = 1'b0; hold++; end else rready = 1'b1;
                default: rready = 1'b1;
            endcase
            cyc++;
        end
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL rd_timeout: read at %h len %0d got %0d beats, want %0d", base, len, recv, len + 1);
        end
        rd_req = 1'b0; rready = 1'b0; rlast = 1'b0; arvalid = 1'b0;
        @(negedge aclk);
        n_tests++;
        if (bus.arready_o !== 1'b1 || bus.rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_idle: arready %b rvalid %b after rlast, want 1 0", bus.arready_o, bus.rvalid_o);
        end
        if (aw_pend) begin
            n_tests++;
            if (bus.awready_o !== 1'b1) begin
                n_fail++; $display("FAIL aw_release: awready %b after read, want 1", bus.awready_o);
            end
            awvalid = 1'b0;
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        n_tests++;
        if ({bus.awready_o, bus.wready_o, bus.bvalid_o, bus.arready_o, bus.rvalid_o} !== 5'b0) begin
            n_fail++; $display("FAIL rst_outputs: got %b want 00000",
                {bus.awready_o, bus.wready_o, bus.bvalid_o, bus.arready_o, bus.rvalid_o});
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        n_tests++;
        if ({bus.awready_o, bus.wready_o, bus.bvalid_o, bus.arready_o, bus.rvalid_o} !== 5'b11010) begin
            n_fail++; $display("FAIL idle_outputs: aw w b ar r got %b want 11010",
                {bus.awready_o, bus.wready_o, bus.bvalid_o, bus.arready_o, bus.rvalid_o});
        end
        n_tests++;
        if (bus.usr_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_rdata: got %h want 00000000", bus.usr_dat_o);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_preload();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; mbuf[i] = '1; end
            write_burst(AW'(b * 256), 255, 1'b0);
        end
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEADBEEF; mbuf[0] = 4'hF;
        write_burst(10'h010, 0, 1'b0);
        read_burst(10'h010, 0, 0, 1'b0);
        n_tests++;
        if (last_rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_rd: got %h want deadbeef", last_rd);
        end
    endtask

    task automatic test_byte_mask();
        wbuf[0] = 32'h11223344; mbuf[0] = 4'hF;
        write_burst(10'h3FF, 0, 1'b0);
        wbuf[0] = 32'hAABBCCDD; mbuf[0] = 4'b0101;
        write_burst(10'h3FF, 0, 1'b0);
        read_burst(10'h3FF, 0, 0, 1'b0);
        n_tests++;
        if (last_rd !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL byte_mask: got %h want 11bb33dd", last_rd);
        end
    endtask

    task automatic test_read_backpressure();
        for (int i = 0; i < 4; i++) begin wbuf[i] = DW'(i); mbuf[i] = '1; end
        write_burst(10'h000, 3, 1'b0);
        read_burst(10'h000, 3, 2, 1'b0);
    endtask

    task automatic test_simultaneous();
        wvalid = 1'b0;
        awvalid = 1'b1;
        read_burst(10'h040, 3, 1, 1'b1);
        wbuf[0] = $urandom; mbuf[0] = 4'hF;
        write_burst(10'h050, 0, 1'b0);
        read_burst(10'h050, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        int beat = 0, cyc = 0;
        bit hs_w;
        logic [AW-1:0] base = 10'h100;
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; mbuf[i] = '1; end
        wr_mode = 1'b1; awvalid = 1'b1; wvalid = 1'b1; wlast = 1'b0;
        cur_addr = base; wdata = wbuf[0]; wbm = mbuf[0];
        while (beat < 2 && cyc < 40) begin
            @(negedge aclk);
            hs_w = wvalid & bus.wready_o;
            if (hs_w) model_mem[base + AW'(beat)] = wdata;
            @(posedge aclk); #1;
            awvalid = 1'b0;
            if (hs_w) begin beat++; cur_addr = base + AW'(beat); wdata = wbuf[beat]; end
            cyc++;
        end
        aresetn = 1'b0;
        @(negedge aclk);
        n_tests++;
        if ({bus.awready_o, bus.wready_o, bus.bvalid_o, bus.arready_o, bus.rvalid_o} !== 5'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b want 00000",
                {bus.awready_o, bus.wready_o, bus.bvalid_o, bus.arready_o, bus.rvalid_o});
        end
        @(posedge aclk); #1;
        aresetn = 1'b1; wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        @(negedge aclk);
        n_tests++;
        if (bus.arready_o !== 1'b1 || bus.usr_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL midrst_idle: arready %b rdata %h, want 1 00000000", bus.arready_o, bus.usr_dat_o);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            n_tests++;
            if (bus.bvalid_o !== 1'b0 || bus.rvalid_o !== 1'b0) begin
                n_fail++; $display("FAIL midrst_noresp: bvalid %b rvalid %b, want 0 0", bus.bvalid_o, bus.rvalid_o);
            end
        end
        @(posedge aclk); #1;
        bready = 1'b0;
        read_burst(base, 3, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [AW-1:0] base;
        int len;
        for (int t = 0; t < 10; t++) begin
            base = AW'($urandom);
            len  = $urandom_range(0, 15);
            for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; mbuf[i] = NB'($urandom); end
            write_burst(base, len, 1'b1);
            read_burst(base, len, 1, 1'b0);
            read_burst(AW'($urandom), $urandom_range(0, 7), $urandom_range(0, 1), 1'b0);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) begin wbuf[i] = $urandom; mbuf[i] = '1; end
        write_burst(10'h3FD, 5, 1'b0);
        read_burst(10'h3FD, 5, 0, 1'b0);
    endtask

`ifdef AXI4_USR_MEM_BP_EN
    task automatic test_bp();
        saw_wready_low = 1'b0;
        for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; mbuf[i] = '1; end
        write_burst(10'h000, 15, 1'b0);
        read_burst(10'h000, 15, 0, 1'b0);
        n_tests++;
        if (!saw_wready_low) begin
            n_fail++; $display("FAIL bp_wready: saw no wready=0 cycle in WR, want at least one");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_preload();
        test_single();
        test_byte_mask();
        test_read_backpressure();
        test_simultaneous();
        test_reset_mid_burst();
        test_random();
        test_wrap();
`ifdef AXI4_USR_MEM_BP_EN
        test_bp();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
